// File: rtl/falcon_loader_pkg.sv
// rtl/falcon_loader_pkg.sv - shared types and constants for the UART boot loader
// Purpose : loader FSM state encoding, default framing bytes and an alignment helper.
// Ports   : none (package).
package falcon_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    DRAIN,
    RESP
  } loader_state_t;

  localparam logic [7:0]  DEF_SYNC_BYTE      = 8'hB0;
  localparam logic [7:0]  DEF_ACK_BYTE       = 8'h06;
  localparam logic [7:0]  DEF_NAK_BYTE       = 8'h15;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  // Only the two low bits decide alignment, so only those are passed in.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - UART byte streams and memory write port of the boot loader
// Purpose : bundles the rx/tx byte handshakes and the 32-bit memory write request.
// Ports   : rx_complete/rx_data (uart rx), tx_valid/tx_data/tx_complete (uart tx),
//           mem_valid/mem_addr/mem_wdata/mem_wmask/mem_ready (memory write port).
//           master = loader side, slave = uart + memory arbiter side.
interface uart_loader_if;

  logic        rx_complete;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;

  modport master (
    input  rx_complete, rx_data, tx_complete, mem_ready,
    output tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    output rx_complete, rx_data, tx_complete, mem_ready,
    input  tx_valid, tx_data, mem_valid, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - packs a byte stream into little-endian 32-bit words
// Purpose : shift register + byte index; flags the byte that completes a word.
// Ports   : clock, reset_n (async, active-low), clear (restart at byte 0),
//           byte_valid/byte_data (input byte), word (assembled word, valid with
//           word_ready), word_ready (combinational pulse on the 4th byte).
module loader_word_assembler (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  // Holds the three earlier bytes of the current word, oldest in [7:0].
  logic [23:0] shift_q;
  logic [1:0]  byte_idx_q;

  // The completing byte is used directly so the word is available in the
  // same cycle it arrives.
  assign word       = {byte_data, shift_q};
  assign word_ready = byte_valid && (byte_idx_q == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (byte_valid) begin
      shift_q    <= {byte_data, shift_q[23:8]};
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - parses a framed boot image from the UART and writes it to memory
// Purpose : frame = SYNC, ADDR[31:0] LE, LEN[31:0] LE, LEN data bytes, CSUM (sum mod 256).
//           Data is written as 32-bit words, an ACK/NAK byte is returned, and on
//           success the CPU is released from reset at the load address.
// Ports   : clock, reset_n (async, active-low),
//           bus (uart_loader_if.master: rx stream, tx handshake, memory write port),
//           cpu_reset_hold (CPU held in reset while 1), boot_addr (CPU start address),
//           busy (frame in progress).
module uart_loader
  import falcon_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_loader_if.master      bus,
  output logic               cpu_reset_hold,
  output logic [31:0]        boot_addr,
  output logic               busy
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  loader_state_t state_q, state_d;

  logic        err_q;
  logic        err_set;
  logic [7:0]  csum_q;
  logic [31:0] cur_addr_q;
  logic [31:0] frame_addr_q;
  logic [31:0] remaining_q;
  logic [31:0] timer_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        tx_valid_c;
  logic [7:0]  tx_data_c;

  logic        idle_sync;
  logic        collecting;
  logic        byte_in;
  logic        asm_valid;
  logic        word_ready;
  logic [31:0] word;
  logic        mem_accept;
  logic        timed_out;
  logic        overflow;
  logic        issue;

  assign collecting = state_q inside {ADDR, LEN, DATA, CSUM};
  assign idle_sync  = (state_q == IDLE) && bus.rx_complete && (bus.rx_data == SYNC_BYTE);
  // Bytes outside the collecting states (DRAIN, RESP) are dropped here.
  assign byte_in    = collecting && bus.rx_complete;
  assign asm_valid  = byte_in && (state_q != CSUM);
  assign mem_accept = mem_valid_q && bus.mem_ready;
  // A byte in the timeout cycle wins, hence the !rx_complete term.
  assign timed_out  = collecting && !bus.rx_complete && (timer_q == TIMEOUT_LAST);
  // A write being accepted in the same cycle frees the request slot.
  assign overflow   = (state_q == DATA) && word_ready && mem_valid_q && !bus.mem_ready;
  assign issue      = (state_q == DATA) && word_ready && !overflow;

  // ADDR and LEN fields are assembled by the same shifter as the data words.
  loader_word_assembler u_word_assembler (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (idle_sync),
    .byte_valid (asm_valid),
    .byte_data  (bus.rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_set    = 1'b0;
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    case (state_q)
      IDLE: begin
        if (idle_sync) state_d = ADDR;
      end
      ADDR: begin
        if (word_ready) begin
          if (!is_word_aligned(word[1:0])) begin
            err_set = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = LEN;
          end
        end
      end
      LEN: begin
        if (word_ready) begin
          if (!is_word_aligned(word[1:0])) begin
            err_set = 1'b1;
            state_d = DRAIN;
          end else if (word == 32'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (overflow) begin
          err_set = 1'b1;
          state_d = DRAIN;
        end else if (byte_in && (remaining_q == 32'd1)) begin
          state_d = CSUM;
        end
      end
      CSUM: begin
        if (byte_in) begin
          err_set = (bus.rx_data != csum_q);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_valid_q) state_d = RESP;
      end
      RESP: begin
        tx_valid_c = 1'b1;
        tx_data_c  = err_q ? NAK_BYTE : ACK_BYTE;
        if (bus.tx_complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timed_out) begin
      err_set = 1'b1;
      state_d = DRAIN;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q          <= 1'b0;
      csum_q         <= '0;
      cur_addr_q     <= '0;
      frame_addr_q   <= '0;
      remaining_q    <= '0;
      timer_q        <= '0;
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_reset_hold <= 1'b1;
      boot_addr      <= '0;
    end else begin
      if (idle_sync) begin
        err_q          <= 1'b0;
        csum_q         <= '0;
        cpu_reset_hold <= 1'b1;
      end else if (err_set) begin
        err_q <= 1'b1;
      end

      if (idle_sync || byte_in) begin
        timer_q <= '0;
      end else if (collecting) begin
        timer_q <= timer_q + 32'd1;
      end

      if ((state_q == ADDR) && word_ready && is_word_aligned(word[1:0])) begin
        cur_addr_q   <= word;
        frame_addr_q <= word;
      end else if (mem_accept) begin
        cur_addr_q <= cur_addr_q + 32'd4;
      end

      if ((state_q == LEN) && word_ready) begin
        remaining_q <= word;
      end else if ((state_q == DATA) && byte_in) begin
        remaining_q <= remaining_q - 32'd1;
      end

      if ((state_q == DATA) && byte_in) begin
        csum_q <= csum_q + bus.rx_data;
      end

      // While a request is pending mem_addr equals cur_addr, so a new request
      // issued in the accept cycle targets the following word.
      if (issue) begin
        mem_valid_q <= 1'b1;
        mem_addr_q  <= mem_accept ? (cur_addr_q + 32'd4) : cur_addr_q;
        mem_wdata_q <= word;
      end else if (mem_accept) begin
        mem_valid_q <= 1'b0;
      end

      if ((state_q == RESP) && bus.tx_complete && !err_q) begin
        cpu_reset_hold <= 1'b0;
        boot_addr      <= frame_addr_q;
      end
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_valid_q ? 4'hF : 4'h0;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader
module tb_uart_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_reset_hold;
  logic [31:0] boot_addr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_mask_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  tx_byte;
  bit          tx_got;

  uart_loader_if bus ();

  uart_loader #(.TIMEOUT_CYCLES(50)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus            (bus),
    .cpu_reset_hold (cpu_reset_hold),
    .boot_addr      (boot_addr),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.mem_valid && bus.mem_ready) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
      wr_mask_q.push_back(bus.mem_wmask);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) begin
      @(negedge clock);
      bus.rx_complete = 1'b1;
      bus.rx_data     = frame_q[i];
      @(negedge clock);
      bus.rx_complete = 1'b0;
    end
    frame_q.delete();
  endtask

  task automatic get_tx(input int budget, output logic [7:0] data, output bit got);
    got  = 1'b0;
    data = 8'h00;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (bus.tx_valid) begin
        data = bus.tx_data;
        got  = 1'b1;
      end
    end
    if (got) begin
      bus.tx_complete = 1'b1;
      @(negedge clock);
      bus.tx_complete = 1'b0;
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_mask_q.delete();
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.rx_complete = 1'b0;
    bus.rx_data     = 8'h00;
    bus.tx_complete = 1'b0;
    bus.mem_ready   = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_cpu_hold", cpu_reset_hold, 1);
    check("reset_mem_valid", bus.mem_valid, 0);
    check("reset_tx_valid", bus.tx_valid, 0);
    check("reset_tx_data", bus.tx_data, 0);
    check("reset_busy", busy, 0);
    check("reset_boot_addr", boot_addr, 0);
    check("reset_wmask", bus.mem_wmask, 0);
    reset_n = 1'b1;

    // Good frame, mem_ready tied high.
    clear_writes();
    frame_q = '{8'hB0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
    send_frame();
    get_tx(20, tx_byte, tx_got);
    check("ok_tx_seen", 32'(tx_got), 1);
    check("ok_tx_byte", tx_byte, 8'h06);
    check("ok_write_count", wr_addr_q.size(), 2);
    check("ok_w0_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hDEAD_BEEF, 32'h0000_1000);
    check("ok_w0_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD_BEEF, 32'h4433_2211);
    check("ok_w0_mask", (wr_mask_q.size() > 0) ? wr_mask_q[0] : 4'h0, 4'hF);
    check("ok_w1_addr", (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'hDEAD_BEEF, 32'h0000_1004);
    check("ok_w1_data", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hDEAD_BEEF, 32'h8877_6655);
    check("ok_cpu_release", cpu_reset_hold, 0);
    check("ok_boot_addr", boot_addr, 32'h0000_1000);
    check("ok_busy_idle", busy, 0);

    // Same frame, bad checksum: writes still happen, NAK, CPU held.
    clear_writes();
    frame_q = '{8'hB0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    send_frame();
    get_tx(20, tx_byte, tx_got);
    check("csum_tx_seen", 32'(tx_got), 1);
    check("csum_tx_byte", tx_byte, 8'h15);
    check("csum_write_count", wr_addr_q.size(), 2);
    check("csum_w1_data", (wr_data_q.size() > 1) ? wr_data_q[1] : 32'hDEAD_BEEF, 32'h8877_6655);
    check("csum_cpu_hold", cpu_reset_hold, 1);
    check("csum_boot_addr", boot_addr, 32'h0000_1000);

    // Misaligned address: NAK right after the 4th address byte.
    clear_writes();
    frame_q = '{8'hB0, 8'h02, 8'h10, 8'h00, 8'h00};
    send_frame();
    get_tx(3, tx_byte, tx_got);
    check("align_tx_seen", 32'(tx_got), 1);
    check("align_tx_byte", tx_byte, 8'h15);
    check("align_write_count", wr_addr_q.size(), 0);
    check("align_busy_idle", busy, 0);
    check("align_cpu_hold", cpu_reset_hold, 1);

    // Overflow: first word stalls, second word completes while it is pending.
    clear_writes();
    bus.mem_ready = 1'b0;
    frame_q = '{8'hB0, 8'h00, 8'h20, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
                8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_frame();
    get_tx(90, tx_byte, tx_got);
    check("ovf_no_tx_while_pending", 32'(tx_got), 0);
    check("ovf_mem_valid", bus.mem_valid, 1);
    check("ovf_mem_addr", bus.mem_addr, 32'h0000_2000);
    check("ovf_mem_wdata", bus.mem_wdata, 32'hA4A3_A2A1);
    check("ovf_mem_wmask", bus.mem_wmask, 4'hF);
    check("ovf_busy", busy, 1);
    bus.mem_ready = 1'b1;
    get_tx(10, tx_byte, tx_got);
    check("ovf_tx_seen", 32'(tx_got), 1);
    check("ovf_tx_byte", tx_byte, 8'h15);
    check("ovf_write_count", wr_addr_q.size(), 1);
    check("ovf_w0_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hDEAD_BEEF, 32'hA4A3_A2A1);

    // Timeout after 3 data bytes: NAK about 50 idle clocks later, no partial write.
    clear_writes();
    frame_q = '{8'hB0, 8'h00, 8'h30, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03};
    send_frame();
    get_tx(45, tx_byte, tx_got);
    check("tmo_no_early_tx", 32'(tx_got), 0);
    get_tx(20, tx_byte, tx_got);
    check("tmo_tx_seen", 32'(tx_got), 1);
    check("tmo_tx_byte", tx_byte, 8'h15);
    check("tmo_write_count", wr_addr_q.size(), 0);
    check("tmo_busy_idle", busy, 0);

    // Garbage before SYNC, then an empty (LEN=0) frame.
    clear_writes();
    frame_q = '{8'h00, 8'hFF, 8'h12};
    send_frame();
    check("garbage_busy", busy, 0);
    frame_q = '{8'hB0, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    get_tx(10, tx_byte, tx_got);
    check("empty_tx_seen", 32'(tx_got), 1);
    check("empty_tx_byte", tx_byte, 8'h06);
    check("empty_write_count", wr_addr_q.size(), 0);
    check("empty_cpu_release", cpu_reset_hold, 0);
    check("empty_boot_addr", boot_addr, 32'h0000_4000);

    // Reset mid-DATA with a write pending.
    clear_writes();
    bus.mem_ready = 1'b0;
    frame_q = '{8'hB0, 8'h00, 8'h50, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame();
    check("mid_cpu_hold", cpu_reset_hold, 1);
    check("mid_busy", busy, 1);
    check("mid_mem_valid", bus.mem_valid, 1);
    check("mid_mem_addr", bus.mem_addr, 32'h0000_5000);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_cpu_hold", cpu_reset_hold, 1);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_boot_addr", boot_addr, 0);
    @(negedge clock);
    reset_n       = 1'b1;
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_mem_valid", bus.mem_valid, 0);
    check("post_rst_write_count", wr_addr_q.size(), 0);
    check("post_rst_tx_valid", bus.tx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
